// File: rtl/wb_block_reader_pkg.sv
// Shared Wishbone constants and the reader FSM state type.
// Latency: none (declarations only).
// Backpressure: not applicable.
package wb_reader_pkg;

  localparam int          WB_DW       = 32;
  localparam int          WB_AW       = 32;
  localparam logic [3:0]  WB_SEL_ALL  = 4'hF;
  localparam logic [2:0]  CTI_CLASSIC = 3'b000;
  localparam logic [1:0]  BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } rd_state_t;

endpackage

// File: rtl/wb_block_reader_fifo.sv
// Generic synchronous first-word-fall-through FIFO with a free-slot count.
// Latency: a pushed word is visible on rdata the cycle after the push.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     free
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             pop_en;
  logic             push_en;

  // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign free  = CW'(DEPTH) - count;
  assign rdata = mem[rptr];

  // Pointer and level bookkeeping; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_en) wptr <= wptr + 1'b1;
      if (pop_en)  rptr <= rptr + 1'b1;
      count <= count + CW'(push_en) - CW'(pop_en);
    end
  end

  // Storage array; contents need no reset because the level gates visibility.
  always_ff @(posedge clk) begin
    if (push_en) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/wb_block_reader.sv
// Wishbone classic block-read master streaming words out through a FWFT FIFO.
// Latency: first strobe the cycle after start; each word visible on out_data the cycle after its ack.
// Backpressure: no new strobe is issued unless the FIFO has a free slot; a live strobe is never dropped.
module wb_block_reader
  import wb_reader_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int NB_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WB_AW-1:0]  base_adr,
  input  logic [NB_W-1:0]   nb_words,
  output logic              busy,
  output logic              done,
  output logic [WB_AW-1:0]  wb_adr,
  output logic [WB_DW-1:0]  wb_dat_ms,
  input  logic [WB_DW-1:0]  wb_dat_sm,
  output logic              wb_we,
  output logic [3:0]        wb_sel,
  output logic              wb_stb,
  output logic              wb_cyc,
  input  logic              wb_ack,
  output logic [2:0]        wb_cti,
  output logic [1:0]        wb_bte,
  output logic [WB_DW-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rd_state_t        state, state_n;
  logic [WB_AW-1:0] adr, adr_n;
  logic [NB_W-1:0]  remaining, remaining_n;
  logic             stb, stb_n;

  logic             ack_take;
  logic             pop_fire;
  logic [CW-1:0]    fifo_free;
  logic [CW-1:0]    free_post;
  logic             slot_ok;
  logic             fifo_empty;
  logic             fifo_full_unused;
  logic             adr_lsb_unused;

  // Byte-lane bits of the base address are forced to zero, never looked at.
  assign adr_lsb_unused = ^base_adr[1:0];

  assign ack_take = stb & wb_ack;
  assign pop_fire = out_valid & out_ready;
  // Free slots after this cycle's push/pop, so a strobe only starts when its word has a home.
  assign free_post = fifo_free + CW'(pop_fire) - CW'(ack_take);
  assign slot_ok   = (free_post != '0);

  sync_fifo #(
    .WIDTH (WB_DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ack_take),
    .wdata (wb_dat_sm),
    .pop   (out_ready),
    .rdata (out_data),
    .empty (fifo_empty),
    .full  (fifo_full_unused),
    .free  (fifo_free)
  );

  assign out_valid = ~fifo_empty;

  assign wb_stb    = stb;
  assign wb_cyc    = stb;
  assign wb_adr    = adr;
  assign wb_dat_ms = '0;
  assign wb_we     = 1'b0;
  assign wb_sel    = WB_SEL_ALL;
  assign wb_cti    = CTI_CLASSIC;
  assign wb_bte    = BTE_LINEAR;
  assign busy      = (state == READ);
  assign done      = (state == DONE);

  // Next-state, address, word count and strobe decisions.
  always_comb begin
    state_n     = state;
    adr_n       = adr;
    remaining_n = remaining;
    stb_n       = stb;
    case (state)
      IDLE: begin
        if (start) begin
          if (nb_words != '0) begin
            state_n     = READ;
            adr_n       = {base_adr[WB_AW-1:2], 2'b00};
            remaining_n = nb_words;
            stb_n       = slot_ok;
          end else begin
            state_n = DONE;
          end
        end
      end
      READ: begin
        if (ack_take) begin
          adr_n       = adr + 32'd4;
          remaining_n = remaining - 1'b1;
          if (remaining == NB_W'(1)) begin
            stb_n   = 1'b0;
            state_n = DONE;
          end else begin
            stb_n = slot_ok;
          end
        end else if (!stb) begin
          // Stalled on a full FIFO; a live strobe is held until its ack.
          stb_n = slot_ok;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        stb_n   = 1'b0;
      end
    endcase
  end

  // State and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      adr       <= '0;
      remaining <= '0;
      stb       <= 1'b0;
    end else begin
      state     <= state_n;
      adr       <= adr_n;
      remaining <= remaining_n;
      stb       <= stb_n;
    end
  end

endmodule

// File: tb/tb_wb_block_reader.sv
// Directed bench for wb_block_reader against a Wishbone memory slave model.
// Latency: slave runs either registered-ack or combinational-ack with 0-3 random waits.
// Backpressure: out_ready is driven per scenario to fill and drain the output FIFO.
module tb_wb_block_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] base_adr;
  logic [15:0] nb_words;
  logic        busy;
  logic        done;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_ms;
  logic [31:0] wb_dat_sm;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic        wb_stb;
  logic        wb_cyc;
  logic        wb_ack;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  wb_block_reader #(.FIFO_DEPTH(4), .NB_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_adr(base_adr), .nb_words(nb_words),
    .busy(busy), .done(done), .wb_adr(wb_adr), .wb_dat_ms(wb_dat_ms),
    .wb_dat_sm(wb_dat_sm), .wb_we(wb_we), .wb_sel(wb_sel), .wb_stb(wb_stb),
    .wb_cyc(wb_cyc), .wb_ack(wb_ack), .wb_cti(wb_cti), .wb_bte(wb_bte),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- slave model: 64 words mapped from byte address 0xF0 ----------------
  logic [31:0] mem [64];
  logic        comb_mode;
  logic        ack_r;
  logic [31:0] dat_r;
  logic [1:0]  wcnt;
  logic [1:0]  wtarget;
  logic        ack_comb;

  function automatic logic [5:0] widx(input logic [31:0] a);
    logic [31:0] d;
    d = a - 32'hF0;
    return d[7:2];
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = i * 32'h11111111;
  end

  assign ack_comb  = comb_mode & wb_stb & (wcnt == wtarget);
  assign wb_ack    = comb_mode ? ack_comb : ack_r;
  assign wb_dat_sm = comb_mode ? mem[widx(wb_adr)] : dat_r;

  always @(posedge clk) begin
    ack_r <= wb_stb & ~ack_r & ~comb_mode;
    dat_r <= mem[widx(wb_adr)];
    if (rst || !wb_stb) begin
      wcnt <= 2'd0;
    end else if (ack_comb) begin
      wcnt    <= 2'd0;
      wtarget <= 2'($urandom_range(0, 3));
    end else begin
      wcnt <= wcnt + 2'd1;
    end
  end

  // ---------------- monitor, sampled on the falling edge ----------------
  logic [31:0] ack_adr_q [$];
  logic [31:0] out_q [$];
  int          n_acks, n_done, n_stb, hold_viol, cyc_mismatch;
  logic        prev_stb, prev_ack;
  logic [31:0] prev_adr;

  always @(negedge clk) begin
    if (wb_stb && wb_ack) begin
      ack_adr_q.push_back(wb_adr);
      n_acks++;
    end
    if (out_valid && out_ready) out_q.push_back(out_data);
    if (done) n_done++;
    if (wb_stb) n_stb++;
    if (wb_cyc !== wb_stb) cyc_mismatch++;
    if (prev_stb && !prev_ack && (wb_stb !== 1'b1 || wb_adr !== prev_adr)) hold_viol++;
    prev_stb = wb_stb & ~rst;
    prev_ack = wb_ack;
    prev_adr = wb_adr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    ack_adr_q.delete();
    out_q.delete();
    n_acks = 0; n_done = 0; n_stb = 0; hold_viol = 0; cyc_mismatch = 0;
  endtask

  task automatic start_block(input logic [31:0] b, input logic [15:0] n);
    start = 1'b1; base_adr = b; nb_words = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (done) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_adr = '0; nb_words = '0; out_ready = 1'b0; comb_mode = 1'b0;
    prev_stb = 1'b0; prev_ack = 1'b0; prev_adr = '0; wtarget = 2'd0;
    tick(); tick();
    checks++; if (wb_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", wb_stb); end
    checks++; if (wb_cyc !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b want 0", wb_cyc); end
    checks++; if (wb_adr !== 32'h0) begin errors++; $display("FAIL reset_adr: got %h want 0", wb_adr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if ({wb_we, wb_sel, wb_cti, wb_bte} !== {1'b0, 4'hF, 3'b000, 2'b00} || wb_dat_ms !== 32'h0) begin
      errors++; $display("FAIL reset_consts: we=%b sel=%h cti=%b bte=%b dat=%h", wb_we, wb_sel, wb_cti, wb_bte, wb_dat_ms);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_block();
    logic [31:0] exp_adr [5];
    logic [31:0] exp_dat [5];
    logic [31:0] got;
    bit ok;
    int busy_gaps;
    exp_adr = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
    exp_dat = '{32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
    comb_mode = 1'b0; out_ready = 1'b1; clear_mon();
    start_block(32'h100, 16'd5);
    busy_gaps = 0; ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin ok = 1'b1; break; end
      if (!busy) busy_gaps++;
      tick();
    end
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: no done within 100 cycles"); end
    checks++; if (busy_gaps !== 0) begin errors++; $display("FAIL basic_busy: low for %0d cycles, want 0", busy_gaps); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done: got %b want 0", busy); end
    for (int i = 0; i < 6; i++) tick();
    checks++; if (ack_adr_q.size() !== 5) begin errors++; $display("FAIL basic_ack_count: got %0d want 5", ack_adr_q.size()); end
    for (int k = 0; k < 5; k++) begin
      got = (k < ack_adr_q.size()) ? ack_adr_q[k] : 32'hxxxxxxxx;
      checks++; if (got !== exp_adr[k]) begin errors++; $display("FAIL basic_adr[%0d]: got %h want %h", k, got, exp_adr[k]); end
    end
    checks++; if (out_q.size() !== 5) begin errors++; $display("FAIL basic_out_count: got %0d want 5", out_q.size()); end
    for (int k = 0; k < 5; k++) begin
      got = (k < out_q.size()) ? out_q[k] : 32'hxxxxxxxx;
      checks++; if (got !== exp_dat[k]) begin errors++; $display("FAIL basic_data[%0d]: got %h want %h", k, got, exp_dat[k]); end
    end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", n_done); end
    checks++; if (hold_viol !== 0) begin errors++; $display("FAIL basic_hold: got %0d violations want 0", hold_viol); end
  endtask

  task automatic test_zero_words();
    comb_mode = 1'b0; out_ready = 1'b1; clear_mon();
    start_block(32'h300, 16'd0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_done: got %b want 0", busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width: got %b want 0", done); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_after: got %b want 0", busy); end
    checks++; if (n_stb !== 0) begin errors++; $display("FAIL zero_stb: got %0d strobe cycles want 0", n_stb); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL zero_done_pulses: got %0d want 1", n_done); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_dat [10];
    logic [31:0] got;
    bit ok;
    exp_dat = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555,
                32'h66666666, 32'h77777777, 32'h88888888, 32'h99999999, 32'hAAAAAAAA};
    comb_mode = 1'b0; out_ready = 1'b0; clear_mon();
    start_block(32'hF4, 16'd10);
    for (int i = 0; i < 40; i++) tick();
    checks++; if (n_acks !== 4) begin errors++; $display("FAIL bp_acks_full: got %0d want 4", n_acks); end
    checks++; if (wb_stb !== 1'b0) begin errors++; $display("FAIL bp_stb_full: got %b want 0", wb_stb); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy_full: got %b want 1", busy); end
    checks++; if (out_data !== 32'h11111111) begin errors++; $display("FAIL bp_head: got %h want 11111111", out_data); end
    out_ready = 1'b1;
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: no done within 200 cycles"); end
    for (int i = 0; i < 8; i++) tick();
    checks++; if (n_acks !== 10) begin errors++; $display("FAIL bp_acks_total: got %0d want 10", n_acks); end
    checks++; if (out_q.size() !== 10) begin errors++; $display("FAIL bp_out_count: got %0d want 10", out_q.size()); end
    for (int k = 0; k < 10; k++) begin
      got = (k < out_q.size()) ? out_q[k] : 32'hxxxxxxxx;
      checks++; if (got !== exp_dat[k]) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", k, got, exp_dat[k]); end
    end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL bp_done_pulses: got %0d want 1", n_done); end
    checks++; if (hold_viol !== 0) begin errors++; $display("FAIL bp_hold: got %0d violations want 0", hold_viol); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] got;
    logic [31:0] want;
    bit ok;
    comb_mode = 1'b1; out_ready = 1'b1; clear_mon();
    start_block(32'hF4, 16'd12);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin ok = 1'b1; break; end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (!ok) begin errors++; $display("FAIL zw_timeout: no done within 400 cycles"); end
    checks++; if (n_acks !== 12) begin errors++; $display("FAIL zw_acks: got %0d want 12", n_acks); end
    checks++; if (out_q.size() !== 12) begin errors++; $display("FAIL zw_out_count: got %0d want 12", out_q.size()); end
    for (int k = 0; k < 12; k++) begin
      want = (k + 1) * 32'h11111111;
      got  = (k < out_q.size()) ? out_q[k] : 32'hxxxxxxxx;
      checks++; if (got !== want) begin errors++; $display("FAIL zw_data[%0d]: got %h want %h", k, got, want); end
    end
    checks++; if (ack_adr_q.size() < 12 || ack_adr_q[11] !== 32'h120) begin
      errors++; $display("FAIL zw_last_adr: got %h want 00000120", (ack_adr_q.size() >= 12) ? ack_adr_q[11] : 32'hxxxxxxxx);
    end
    checks++; if (hold_viol !== 0) begin errors++; $display("FAIL zw_hold: got %0d violations want 0", hold_viol); end
    checks++; if (cyc_mismatch !== 0) begin errors++; $display("FAIL zw_cyc_eq_stb: got %0d mismatches want 0", cyc_mismatch); end
    comb_mode = 1'b0;
  endtask

  task automatic test_start_ignored();
    logic [31:0] exp_adr [6];
    logic [31:0] got;
    bit ok;
    exp_adr = '{32'hF4, 32'hF8, 32'hFC, 32'h100, 32'h104, 32'h108};
    comb_mode = 1'b0; out_ready = 1'b1; clear_mon();
    start_block(32'hF4, 16'd6);
    tick(); tick(); tick();
    start_block(32'h800, 16'd2);
    wait_done(100, ok);
    for (int i = 0; i < 6; i++) tick();
    checks++; if (!ok) begin errors++; $display("FAIL si_timeout: no done within 100 cycles"); end
    checks++; if (n_acks !== 6) begin errors++; $display("FAIL si_acks: got %0d want 6", n_acks); end
    for (int k = 0; k < 6; k++) begin
      got = (k < ack_adr_q.size()) ? ack_adr_q[k] : 32'hxxxxxxxx;
      checks++; if (got !== exp_adr[k]) begin errors++; $display("FAIL si_adr[%0d]: got %h want %h", k, got, exp_adr[k]); end
    end
    checks++; if (out_q.size() < 6 || out_q[5] !== 32'h66666666) begin
      errors++; $display("FAIL si_last_data: got %h want 66666666", (out_q.size() >= 6) ? out_q[5] : 32'hxxxxxxxx);
    end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL si_done_pulses: got %0d want 1", n_done); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_adr [3];
    logic [31:0] exp_dat [3];
    logic [31:0] got;
    bit ok;
    exp_adr = '{32'h130, 32'h134, 32'h138};
    exp_dat = '{32'h11111110, 32'h22222221, 32'h33333332};
    comb_mode = 1'b0; out_ready = 1'b0; clear_mon();
    start_block(32'hF4, 16'd8);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (n_acks >= 3) begin ok = 1'b1; break; end
      tick();
    end
    checks++; if (!ok) begin errors++; $display("FAIL rm_timeout: 3 acks not seen within 100 cycles"); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_valid_before: got %b want 1", out_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (wb_stb !== 1'b0 || wb_cyc !== 1'b0) begin errors++; $display("FAIL rm_stb_cyc: got %b%b want 00", wb_stb, wb_cyc); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", busy); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (n_done !== 0) begin errors++; $display("FAIL rm_no_done: got %0d pulses want 0", n_done); end
    checks++; if (n_acks !== 3) begin errors++; $display("FAIL rm_acks: got %0d want 3", n_acks); end
    clear_mon(); out_ready = 1'b1;
    start_block(32'h130, 16'd3);
    wait_done(100, ok);
    for (int i = 0; i < 6; i++) tick();
    checks++; if (!ok) begin errors++; $display("FAIL rm_restart_timeout: no done within 100 cycles"); end
    for (int k = 0; k < 3; k++) begin
      got = (k < ack_adr_q.size()) ? ack_adr_q[k] : 32'hxxxxxxxx;
      checks++; if (got !== exp_adr[k]) begin errors++; $display("FAIL rm_adr[%0d]: got %h want %h", k, got, exp_adr[k]); end
      got = (k < out_q.size()) ? out_q[k] : 32'hxxxxxxxx;
      checks++; if (got !== exp_dat[k]) begin errors++; $display("FAIL rm_data[%0d]: got %h want %h", k, got, exp_dat[k]); end
    end
    checks++; if (out_q.size() !== 3) begin errors++; $display("FAIL rm_out_count: got %0d want 3", out_q.size()); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL rm_done_pulses: got %0d want 1", n_done); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic_block();
    test_zero_words();
    test_backpressure();
    test_zero_wait();
    test_start_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
